// File: rtl/tmr_mon_pkg.sv
// Shared types for the TMR fault monitor.
// When TMR_MON_TIMESTAMP_EN is defined, the event record also carries a cycle timestamp.
package tmr_mon_pkg;

  localparam int unsigned TS_W = 32;

  typedef enum logic [2:0] {
    CLS_OK      = 3'd0,
    CLS_SINGLE1 = 3'd1,
    CLS_SINGLE2 = 3'd2,
    CLS_SINGLE3 = 3'd3,
    CLS_UNCORR  = 3'd4
  } cls_e;

  typedef enum logic [1:0] {
    KIND_TRANSIENT  = 2'd0,
    KIND_PERSISTENT = 2'd1,
    KIND_UNCORR     = 2'd2
  } evt_kind_e;

  typedef struct packed {
`ifdef TMR_MON_TIMESTAMP_EN
    logic [TS_W-1:0] stamp;
`endif
    logic [1:0]      lane;
    evt_kind_e       kind;
  } evt_rec_t;

  // Classify a sample from the three pairwise equality results.
  function automatic cls_e classify(input logic eq12, input logic eq13, input logic eq23);
    cls_e c;
    if (eq12 && eq13)       c = CLS_OK;
    else if (eq23 && !eq12) c = CLS_SINGLE1;
    else if (eq13 && !eq12) c = CLS_SINGLE2;
    else if (eq12 && !eq13) c = CLS_SINGLE3;
    else                    c = CLS_UNCORR;
    return c;
  endfunction

endpackage

// File: rtl/tmr_lane_tracker.sv
// Per-lane statistics: saturating error counter, consecutive-fault streak and sticky failed flag.
module tmr_lane_tracker
  import tmr_mon_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned PERSIST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             sample_en,
  input  logic             hit,
  output logic [CNT_W-1:0] err_cnt,
  output logic             failed,
  output logic             fail_set_c
);

  localparam int unsigned STREAK_W = 8;

  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic [STREAK_W-1:0] streak_q, streak_d, streak_inc;
  logic                failed_q, failed_d;

  always_comb begin
    err_cnt_d  = err_cnt_q;
    streak_d   = streak_q;
    failed_d   = failed_q;
    fail_set_c = 1'b0;
    streak_inc = (streak_q == '1) ? streak_q : streak_q + STREAK_W'(1);
    if (clr) begin
      err_cnt_d = '0;
      streak_d  = '0;
      failed_d  = 1'b0;
    end else if (sample_en) begin
      if (hit) begin
        streak_d = streak_inc;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        // Flag rises on the sample that brings the streak to PERSIST.
        if (!failed_q && (streak_inc >= STREAK_W'(PERSIST))) begin
          failed_d   = 1'b1;
          fail_set_c = 1'b1;
        end
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
      streak_q  <= '0;
      failed_q  <= 1'b0;
    end else begin
      err_cnt_q <= err_cnt_d;
      streak_q  <= streak_d;
      failed_q  <= failed_d;
    end
  end

  assign err_cnt = err_cnt_q;
  assign failed  = failed_q;

endmodule

// File: rtl/tmr_fault_monitor.sv
// Observes three replica values, tracks per-lane faults and emits prioritised events over a valid/ready port.
// Optional: TMR_MON_TIMESTAMP_EN adds evt_time, stamped from a free-running cycle counter.
module tmr_fault_monitor
  import tmr_mon_pkg::*;
#(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned PERSIST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] q_1,
  input  logic [WIDTH-1:0] q_2,
  input  logic [WIDTH-1:0] q_3,
  input  logic             clr,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_lane,
  output logic [1:0]       evt_kind,
  output logic             evt_overflow,
`ifdef TMR_MON_TIMESTAMP_EN
  output logic [31:0]      evt_time,
`endif
  output logic [CNT_W-1:0] err_cnt_1,
  output logic [CNT_W-1:0] err_cnt_2,
  output logic [CNT_W-1:0] err_cnt_3,
  output logic [2:0]       lane_failed
);

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_e;

  state_e   state_q, state_d;
  cls_e     prev_q, prev_d;
  evt_rec_t rec_q, rec_d, new_rec_c;
  logic     ovf_q, ovf_d;
  logic     gen_c;
  cls_e     cls_c;
  logic [2:0] hit_c, fail_set_c;

  assign cls_c = classify(q_1 == q_2, q_1 == q_3, q_2 == q_3);
  assign hit_c = {cls_c == CLS_SINGLE3, cls_c == CLS_SINGLE2, cls_c == CLS_SINGLE1};

  tmr_lane_tracker #(.CNT_W(CNT_W), .PERSIST(PERSIST)) u_lane1 (
    .clk(clk), .rst(rst), .clr(clr), .sample_en(sample_en), .hit(hit_c[0]),
    .err_cnt(err_cnt_1), .failed(lane_failed[0]), .fail_set_c(fail_set_c[0]));
  tmr_lane_tracker #(.CNT_W(CNT_W), .PERSIST(PERSIST)) u_lane2 (
    .clk(clk), .rst(rst), .clr(clr), .sample_en(sample_en), .hit(hit_c[1]),
    .err_cnt(err_cnt_2), .failed(lane_failed[1]), .fail_set_c(fail_set_c[1]));
  tmr_lane_tracker #(.CNT_W(CNT_W), .PERSIST(PERSIST)) u_lane3 (
    .clk(clk), .rst(rst), .clr(clr), .sample_en(sample_en), .hit(hit_c[2]),
    .err_cnt(err_cnt_3), .failed(lane_failed[2]), .fail_set_c(fail_set_c[2]));

`ifdef TMR_MON_TIMESTAMP_EN
  logic [TS_W-1:0] cyc_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc_q <= '0;
    else     cyc_q <= cyc_q + TS_W'(1);
  end
  assign evt_time = rec_q.stamp;
`endif

  // Event source selection, highest priority first; losers are simply discarded.
  always_comb begin
    gen_c     = 1'b0;
    new_rec_c = '0;
`ifdef TMR_MON_TIMESTAMP_EN
    new_rec_c.stamp = cyc_q;
`endif
    if (!clr) begin
      if (sample_en && (cls_c == CLS_UNCORR) && (prev_q != CLS_UNCORR)) begin
        gen_c          = 1'b1;
        new_rec_c.lane = 2'd0;
        new_rec_c.kind = KIND_UNCORR;
      end else if (|fail_set_c) begin
        gen_c          = 1'b1;
        new_rec_c.lane = fail_set_c[0] ? 2'd1 : (fail_set_c[1] ? 2'd2 : 2'd3);
        new_rec_c.kind = KIND_PERSISTENT;
      end else if (sample_en && (|hit_c) && (cls_c != prev_q)) begin
        gen_c          = 1'b1;
        new_rec_c.lane = hit_c[0] ? 2'd1 : (hit_c[1] ? 2'd2 : 2'd3);
        new_rec_c.kind = KIND_TRANSIENT;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rec_d   = rec_q;
    ovf_d   = ovf_q;
    prev_d  = sample_en ? cls_c : prev_q;
    if (clr) begin
      state_d = S_IDLE;
      rec_d   = '0;
      ovf_d   = 1'b0;
      prev_d  = CLS_OK;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gen_c) begin
            rec_d   = new_rec_c;
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (evt_ready) begin
            if (gen_c) rec_d = new_rec_c;
            else       state_d = S_IDLE;
          end else if (gen_c) begin
            ovf_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rec_q   <= '0;
      ovf_q   <= 1'b0;
      prev_q  <= CLS_OK;
    end else begin
      state_q <= state_d;
      rec_q   <= rec_d;
      ovf_q   <= ovf_d;
      prev_q  <= prev_d;
    end
  end

  assign evt_valid    = (state_q == S_HOLD);
  assign evt_lane     = rec_q.lane;
  assign evt_kind     = rec_q.kind;
  assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Directed bench for tmr_fault_monitor (CNT_W=2, PERSIST=4); connects evt_time when TMR_MON_TIMESTAMP_EN is defined.
module tb_tmr_fault_monitor;

  localparam int unsigned WIDTH   = 64;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned PERSIST = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             sample_en;
  logic [WIDTH-1:0] q_1, q_2, q_3;
  logic             clr;
  logic             evt_valid;
  logic             evt_ready;
  logic [1:0]       evt_lane;
  logic [1:0]       evt_kind;
  logic             evt_overflow;
`ifdef TMR_MON_TIMESTAMP_EN
  logic [31:0]      evt_time;
`endif
  logic [CNT_W-1:0] err_cnt_1, err_cnt_2, err_cnt_3;
  logic [2:0]       lane_failed;

  int n_checks = 0;
  int n_fail   = 0;

  tmr_fault_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .PERSIST(PERSIST)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en),
    .q_1(q_1), .q_2(q_2), .q_3(q_3), .clr(clr),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_lane(evt_lane), .evt_kind(evt_kind), .evt_overflow(evt_overflow),
`ifdef TMR_MON_TIMESTAMP_EN
    .evt_time(evt_time),
`endif
    .err_cnt_1(err_cnt_1), .err_cnt_2(err_cnt_2), .err_cnt_3(err_cnt_3),
    .lane_failed(lane_failed));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_q(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c);
    q_1 = a; q_2 = b; q_3 = c;
  endtask

  task automatic check_evt(input string tag, input logic v, input logic [1:0] lane, input logic [1:0] kind);
    check({tag, "_valid"}, 64'(evt_valid), 64'(v));
    if (v) begin
      check({tag, "_lane"}, 64'(evt_lane), 64'(lane));
      check({tag, "_kind"}, 64'(evt_kind), 64'(kind));
    end
  endtask

  task automatic check_cnt(input string tag, input int c1, input int c2, input int c3);
    check({tag, "_cnt1"}, 64'(err_cnt_1), 64'(c1));
    check({tag, "_cnt2"}, 64'(err_cnt_2), 64'(c2));
    check({tag, "_cnt3"}, 64'(err_cnt_3), 64'(c3));
  endtask

  initial begin
    rst = 1'b1; sample_en = 1'b0; clr = 1'b0; evt_ready = 1'b0;
    set_q(64'd0, 64'd0, 64'd0);
    #3;
    check_evt("reset", 1'b0, 2'd0, 2'd0);
    check("reset_ovf", 64'(evt_overflow), 64'd0);
    check("reset_failed", 64'(lane_failed), 64'd0);
    check_cnt("reset", 0, 0, 0);
    #9;
    rst = 1'b0;

    // All lanes agree: no events, no counts.
    sample_en = 1'b1;
    set_q(64'd5, 64'd5, 64'd5);
    for (int i = 0; i < 10; i++) begin
      step();
      check("ok_valid", 64'(evt_valid), 64'd0);
    end
    check_cnt("ok", 0, 0, 0);

    // Single transient on lane 2, consumer ready.
    evt_ready = 1'b1;
    set_q(64'd5, 64'd7, 64'd5);
    step();
    check_evt("tr2", 1'b1, 2'd2, 2'd0);
    check_cnt("tr2", 0, 1, 0);
    check("tr2_failed", 64'(lane_failed), 64'd0);
    set_q(64'd5, 64'd5, 64'd5);
    step();
    check_evt("tr2_ack", 1'b0, 2'd0, 2'd0);

    // Lane 3 faulty for PERSIST samples with consumer stalled: persistent event dropped.
    evt_ready = 1'b0;
    set_q(64'd5, 64'd5, 64'd9);
    for (int i = 0; i < 4; i++) begin
      step();
      check_evt("st3", 1'b1, 2'd3, 2'd0);
    end
    check("st3_ovf", 64'(evt_overflow), 64'd1);
    check("st3_failed", 64'(lane_failed), 64'b100);
    check_cnt("st3", 0, 1, 3);
    sample_en = 1'b0;
    step();
    check_evt("st3_hold", 1'b1, 2'd3, 2'd0);
    evt_ready = 1'b1;
    step();
    check_evt("st3_ack", 1'b0, 2'd0, 2'd0);

    // All three differ: uncorrectable, counters untouched.
    sample_en = 1'b1;
    set_q(64'd1, 64'd2, 64'd3);
    step();
    check_evt("unc", 1'b1, 2'd0, 2'd2);
    check_cnt("unc", 0, 1, 3);
    step();
    check_evt("unc_repeat", 1'b0, 2'd0, 2'd0);
    check("unc_failed", 64'(lane_failed), 64'b100);

    // Lane 1 faulty for 5 samples: transient, then persistent, counter saturates.
    set_q(64'd4, 64'd5, 64'd5);
    step();
    check_evt("l1_tr", 1'b1, 2'd1, 2'd0);
    step();
    check_evt("l1_s2", 1'b0, 2'd0, 2'd0);
    step();
    check_evt("l1_s3", 1'b0, 2'd0, 2'd0);
    step();
    check_evt("l1_pers", 1'b1, 2'd1, 2'd1);
    check("l1_failed", 64'(lane_failed), 64'b101);
    step();
    check_evt("l1_s5", 1'b0, 2'd0, 2'd0);
    check_cnt("l1_sat", 3, 1, 3);
    check("l1_ovf_sticky", 64'(evt_overflow), 64'd1);

    // Park an event in HOLD, then clr with a coincident faulty sample.
    evt_ready = 1'b0;
    set_q(64'd5, 64'd7, 64'd5);
    step();
    check_evt("pre_clr", 1'b1, 2'd2, 2'd0);
    clr = 1'b1;
    step();
    check_evt("clr", 1'b0, 2'd0, 2'd0);
    check_cnt("clr", 0, 0, 0);
    check("clr_ovf", 64'(evt_overflow), 64'd0);
    check("clr_failed", 64'(lane_failed), 64'd0);
    clr = 1'b0;
    step();
    check_evt("post_clr", 1'b1, 2'd2, 2'd0);
    check_cnt("post_clr", 0, 1, 0);

    // Asynchronous reset while holding an event.
    rst = 1'b1;
    #1;
    check_evt("arst", 1'b0, 2'd0, 2'd0);
    check("arst_lane", 64'(evt_lane), 64'd0);
    check("arst_kind", 64'(evt_kind), 64'd0);
    check("arst_ovf", 64'(evt_overflow), 64'd0);
    check("arst_failed", 64'(lane_failed), 64'd0);
    check_cnt("arst", 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
